// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Contents: address/data widths, memory size, reset PC, FSM state enum,
// queue entry payload struct and the PC wrap/increment helpers.
package ifetch_pkg;

  localparam int unsigned PC_W        = 16;
  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned MEM_WORDS   = 512;
  localparam int unsigned QUEUE_DEPTH = 2;
  localparam int unsigned CNT_W       = $clog2(QUEUE_DEPTH + 1);

  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } q_entry_t;

  // MEM_WORDS is a power of two, so the modulo is a mask.
  function automatic logic [PC_W-1:0] pc_wrap(input logic [PC_W-1:0] pc);
    return pc & PC_W'(MEM_WORDS - 1);
  endfunction

  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return (pc == PC_W'(MEM_WORDS - 1)) ? '0 : pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Two-entry FIFO holding returned instructions; slot 0 is always the head so
// the outputs come straight from registers.
// Ports: clk_i, rst_ni, push_i/push_data_i (write), pop_i (read), flush_i
// (clear, wins over push/pop), head_o/head_valid_o (oldest entry), count_o.
module ifetch_queue
  import ifetch_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  q_entry_t         push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output q_entry_t         head_o,
  output logic             head_valid_o,
  output logic [CNT_W-1:0] count_o
);

  q_entry_t ent0_q, ent0_d, ent1_q, ent1_d;
  logic     v0_q, v0_d, v1_q, v1_d;

  // Next-state for the shift-style FIFO.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    v0_d   = v0_q;
    v1_d   = v1_q;
    if (flush_i) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else if (pop_i && push_i) begin
      if (v1_q) begin
        ent0_d = ent1_q;
        ent1_d = push_data_i;
      end else begin
        ent0_d = push_data_i;
      end
    end else if (pop_i) begin
      ent0_d = ent1_q;
      v0_d   = v1_q;
      v1_d   = 1'b0;
    end else if (push_i) begin
      if (!v0_q) begin
        ent0_d = push_data_i;
        v0_d   = 1'b1;
      end else begin
        ent1_d = push_data_i;
        v1_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent0_q <= '0;
      ent1_q <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      v0_q   <= v0_d;
      v1_q   <= v1_d;
    end
  end

  assign head_o       = ent0_q;
  assign head_valid_o = v0_q;
  assign count_o      = CNT_W'(v0_q) + CNT_W'(v1_q);

  // The issue rule in the controller must never let a push overflow.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push_i && !pop_i && !flush_i) |-> !v1_q);

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer for a 512x16 synchronous-read instruction memory.
// Drives the fetch PC, tracks the single outstanding read, buffers returned
// words in ifetch_queue and hands them to decode over valid/ready.
// Ports: clk_i, rst_ni (async active-low), mem_pc_o/mem_instr_i (memory),
// redirect_i/redirect_pc_i (flush + restart), halt_i (stop issuing),
// instr_valid_o/instr_ready_i/instr_o/instr_pc_o (decode handshake).
// Optional: define IFETCH_PERF_EN to add perf_fetched_o (instructions popped)
// and perf_stall_o (RUN cycles with nothing valid), both saturating.
module ifetch_ctrl
  import ifetch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic [PC_W-1:0]    mem_pc_o,
  input  logic [INSTR_W-1:0] mem_instr_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  input  logic               halt_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    instr_pc_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched_o,
  output logic [31:0]        perf_stall_o
`endif
);

  localparam int unsigned FILL_W = CNT_W + 1;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   mem_pc_q, mem_pc_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              pop, push, issue;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  q_count;
  logic              q_valid;
  q_entry_t          q_head, push_entry;

  assign pop  = q_valid & instr_ready_i;
  assign push = inflight_q & ~redirect_i;
  // Queue occupancy once this cycle's pop and return have landed.
  assign fill = FILL_W'(q_count) + FILL_W'(inflight_q) - FILL_W'(pop);

  assign push_entry.instr = mem_instr_i;
  assign push_entry.pc    = req_pc_q;

  // FSM next state plus issue/PC control; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    mem_pc_d   = mem_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    issue      = 1'b0;

    unique case (state_q)
      ST_BOOT: state_d = halt_i ? ST_HALT : ST_RUN;
      ST_RUN:  if (halt_i) state_d = ST_HALT;
      ST_HALT: if (!halt_i) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    if (redirect_i) begin
      mem_pc_d = pc_wrap(redirect_pc_i);
    end else begin
      issue = (state_q == ST_RUN) && !halt_i && (fill < FILL_W'(QUEUE_DEPTH));
      if (issue) begin
        inflight_d = 1'b1;
        req_pc_d   = mem_pc_q;
        mem_pc_d   = pc_incr(mem_pc_q);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_BOOT;
      mem_pc_q   <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_pc_q   <= mem_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  ifetch_queue u_queue (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect_i),
    .head_o       (q_head),
    .head_valid_o (q_valid),
    .count_o      (q_count)
  );

  assign mem_pc_o      = mem_pc_q;
  assign instr_valid_o = q_valid;
  assign instr_o       = q_head.instr;
  assign instr_pc_o    = q_head.pc;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  // Saturating event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop && (perf_fetched_q != 32'hFFFF_FFFF))
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (!q_valid && (state_q == ST_RUN) && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule
